// File: rtl/srv_pkg.sv
// Shared types and encodings for the memory pipeline stage.
// FSM states, exception causes and access-size constants.
package srv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_t;

    localparam logic [1:0] EXC_LOAD_MISALIGN  = 2'd0;
    localparam logic [1:0] EXC_STORE_MISALIGN = 2'd1;
    localparam logic [1:0] EXC_LOAD_FAULT     = 2'd2;
    localparam logic [1:0] EXC_STORE_FAULT    = 2'd3;

    localparam logic [2:0] FN3_B  = 3'b000;
    localparam logic [2:0] FN3_H  = 3'b001;
    localparam logic [2:0] FN3_W  = 3'b010;
    localparam logic [2:0] FN3_D  = 3'b011;
    localparam logic [2:0] FN3_BU = 3'b100;
    localparam logic [2:0] FN3_HU = 3'b101;
    localparam logic [2:0] FN3_WU = 3'b110;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [2:0] off
    );
        logic bad;
        bad = 1'b0;
        unique case (size)
            SZ_B: bad = 1'b0;
            SZ_H: bad = off[0];
            SZ_W: bad = |off[1:0];
            SZ_D: bad = |off;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/output_adj.sv
// Store lane steering: replicates the store operand across the bus
// word and builds the byte-enable mask for the addressed lane.
module output_adj
    import srv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int LSB  = $clog2(XLEN / 8)
) (
    input  logic [1:0]        size,
    input  logic [LSB-1:0]    offset,
    input  logic [XLEN-1:0]   data,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN/8-1:0] mask
);

    localparam int MW = XLEN / 8;

    logic [MW-1:0] base;

    always_comb begin
        wdata = {(XLEN / 32){data[31:0]}};
        base  = MW'(4'hF);
        unique case (size)
            SZ_B: begin
                wdata = {MW{data[7:0]}};
                base  = MW'(1);
            end
            SZ_H: begin
                wdata = {(XLEN / 16){data[15:0]}};
                base  = MW'(3);
            end
            SZ_W: begin
                wdata = {(XLEN / 32){data[31:0]}};
                base  = MW'(4'hF);
            end
            SZ_D: begin
                // A doubleword only exists on a 64-bit bus.
                if (XLEN == 64) begin
                    wdata = data;
                    base  = '1;
                end
            end
        endcase
        mask = base << offset;
    end

endmodule

// File: rtl/memory_stage_hs.sv
// Memory stage: issues loads/stores on a req/ack bus, extracts load
// data, raises alignment/bus exceptions and stalls the pipeline.
module memory_stage_hs
    import srv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15,
    parameter int LSB     = $clog2(XLEN / 8)
) (
    input  logic                clk,
    input  logic                async_rst_n,
    input  logic                clk_en,
    input  logic                flush,
    input  logic                valid_in,
    input  logic [31:0]         inst_in,
    input  logic                mem_en_in,
    input  logic                mem_we_in,
    input  logic                lock_in,
    input  logic                wb_en_in,
    input  logic                branch_in,
    input  logic [XLEN-1:0]     alu_in,
    input  logic [XLEN-1:0]     rs2_in,
    input  logic [4:0]          exe_rs1_addr,
    input  logic [4:0]          exe_rs2_addr,
    input  logic                exe_uses_rs1,
    input  logic                exe_uses_rs2,
    output logic                stall,
    output logic                pc_jmp,
    output logic [XLEN-3:0]     pc_target,
    output logic                bus_req,
    output logic                bus_we,
    output logic                bus_lock,
    output logic [XLEN-LSB-1:0] bus_addr,
    output logic [XLEN-1:0]     bus_wdata,
    output logic [XLEN/8-1:0]   bus_mask,
    input  logic                bus_ack,
    input  logic                bus_err,
    input  logic [XLEN-1:0]     bus_rdata,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                exc_valid,
    output logic [1:0]          exc_cause
);

    mem_state_t      state;
    logic [7:0]      cnt;
    logic [2:0]      fn3_q;
    logic [LSB-1:0]  off_q;
    logic [4:0]      rd_q;
    logic            store_q;
    logic            wb_en_q;
    logic            drop_q;
    logic            fault_q;
    logic            armed_q;
    logic [XLEN-1:0] rdata_q;

    logic [XLEN-1:0]   adj_wdata;
    logic [XLEN/8-1:0] adj_mask;

    logic [4:0] rd;
    logic       aligned;
    logic       mem_op;
    logic       issue;
    logic       ack_ok;
    logic       resp_hit;
    logic [7:0] cnt_inc;
    logic       timeout;
    logic       fault_now;
    logic       hold;
    logic       load_use;
    logic       drop;
    logic       unused_bits;

    assign unused_bits = ^{inst_in[31:15], inst_in[6:0]};

    assign rd        = inst_in[11:7];
    assign aligned   = !misaligned(inst_in[13:12], 3'(alu_in[LSB-1:0]));
    assign mem_op    = valid_in & mem_en_in & !flush;
    assign issue     = (state == IDLE) & mem_op & aligned & clk_en;
    assign ack_ok    = bus_ack & armed_q;
    assign resp_hit  = ack_ok | bus_err;
    assign cnt_inc   = cnt + 8'd1;
    assign timeout   = clk_en & (cnt_inc == 8'(TIMEOUT));
    assign fault_now = bus_err | (timeout & !ack_ok);
    assign drop      = drop_q | flush;

    assign hold = (state == ACCESS)
                | ((state == RESP) & !clk_en)
                | issue;

    // Only checked in IDLE: once in RESP the load retires and the
    // pipeline must advance so the dependent op sees the writeback.
    assign load_use = (state == IDLE) & mem_op & aligned
                    & !mem_we_in & wb_en_in & (rd != 5'd0)
                    & (((rd == exe_rs1_addr) & exe_uses_rs1)
                     | ((rd == exe_rs2_addr) & exe_uses_rs2));

    assign stall     = hold | load_use;
    assign pc_jmp    = branch_in & valid_in & !flush;
    assign pc_target = alu_in[XLEN-1:2];

    output_adj #(
        .XLEN (XLEN),
        .LSB  (LSB)
    ) u_adj (
        .size   (inst_in[13:12]),
        .offset (alu_in[LSB-1:0]),
        .data   (rs2_in),
        .wdata  (adj_wdata),
        .mask   (adj_mask)
    );

    logic [XLEN-1:0]  shifted;
    logic signed [7:0]  ld_b;
    logic signed [15:0] ld_h;
    logic signed [31:0] ld_w;
    logic [XLEN-1:0]  load_data;

    assign shifted = rdata_q >> {off_q, 3'b000};
    assign ld_b    = shifted[7:0];
    assign ld_h    = shifted[15:0];
    assign ld_w    = shifted[31:0];

    always_comb begin
        load_data = shifted;
        unique case (fn3_q)
            FN3_B:   load_data = XLEN'(ld_b);
            FN3_H:   load_data = XLEN'(ld_h);
            FN3_W:   load_data = XLEN'(ld_w);
            FN3_BU:  load_data = XLEN'(shifted[7:0]);
            FN3_HU:  load_data = XLEN'(shifted[15:0]);
            FN3_WU:  load_data = XLEN'(shifted[31:0]);
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_lock  <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_mask  <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= '0;
            exc_valid <= 1'b0;
            exc_cause <= 2'd0;
            fn3_q     <= 3'd0;
            off_q     <= '0;
            rd_q      <= 5'd0;
            store_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            drop_q    <= 1'b0;
            fault_q   <= 1'b0;
            armed_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            armed_q <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (clk_en) begin
                        exc_valid <= 1'b0;
                        if (issue) begin
                            state     <= ACCESS;
                            cnt       <= 8'd0;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_we_in;
                            bus_lock  <= lock_in;
                            bus_addr  <= alu_in[XLEN-1:LSB];
                            bus_wdata <= adj_wdata;
                            bus_mask  <= adj_mask;
                            fn3_q     <= inst_in[14:12];
                            off_q     <= alu_in[LSB-1:0];
                            rd_q      <= rd;
                            store_q   <= mem_we_in;
                            wb_en_q   <= wb_en_in;
                            drop_q    <= 1'b0;
                        end else begin
                            wb_valid <= valid_in & !mem_en_in
                                      & wb_en_in & !flush;
                            wb_rd    <= rd;
                            wb_data  <= alu_in;
                            if (mem_op & !aligned) begin
                                exc_valid <= 1'b1;
                                exc_cause <= mem_we_in
                                           ? EXC_STORE_MISALIGN
                                           : EXC_LOAD_MISALIGN;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (flush) drop_q <= 1'b1;
                    // Responses are taken even with clk_en low so the
                    // bus handshake never gets lost.
                    if (resp_hit | timeout) begin
                        state   <= RESP;
                        bus_req <= 1'b0;
                        fault_q <= fault_now;
                        rdata_q <= bus_rdata;
                    end else if (clk_en) begin
                        cnt <= cnt_inc;
                    end
                end
                RESP: begin
                    if (clk_en) begin
                        state     <= IDLE;
                        cnt       <= 8'd0;
                        wb_valid  <= !drop & !fault_q & !store_q & wb_en_q;
                        wb_rd     <= rd_q;
                        wb_data   <= load_data;
                        exc_valid <= !drop & fault_q;
                        exc_cause <= store_q ? EXC_STORE_FAULT
                                             : EXC_LOAD_FAULT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage_hs.sv
// Directed testbench for memory_stage_hs (XLEN 32, TIMEOUT 4).
module tb_memory_stage_hs;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        clk_en, flush, valid_in;
    logic [31:0] inst_in;
    logic        mem_en_in, mem_we_in, lock_in, wb_en_in, branch_in;
    logic [31:0] alu_in, rs2_in;
    logic [4:0]  exe_rs1_addr, exe_rs2_addr;
    logic        exe_uses_rs1, exe_uses_rs2;
    logic        stall, pc_jmp;
    logic [29:0] pc_target;
    logic        bus_req, bus_we, bus_lock;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_mask;
    logic        bus_ack, bus_err;
    logic [31:0] bus_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_stage_hs #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clk(clk), .async_rst_n(async_rst_n),
        .clk_en(clk_en), .flush(flush),
        .valid_in(valid_in), .inst_in(inst_in),
        .mem_en_in(mem_en_in), .mem_we_in(mem_we_in),
        .lock_in(lock_in), .wb_en_in(wb_en_in),
        .branch_in(branch_in), .alu_in(alu_in), .rs2_in(rs2_in),
        .exe_rs1_addr(exe_rs1_addr), .exe_rs2_addr(exe_rs2_addr),
        .exe_uses_rs1(exe_uses_rs1), .exe_uses_rs2(exe_uses_rs2),
        .stall(stall), .pc_jmp(pc_jmp), .pc_target(pc_target),
        .bus_req(bus_req), .bus_we(bus_we), .bus_lock(bus_lock),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_mask(bus_mask), .bus_ack(bus_ack), .bus_err(bus_err),
        .bus_rdata(bus_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .exc_valid(exc_valid),
        .exc_cause(exc_cause)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clk_en = 1'b1; flush = 1'b0; valid_in = 1'b0;
        inst_in = 32'd0; mem_en_in = 1'b0; mem_we_in = 1'b0;
        lock_in = 1'b0; wb_en_in = 1'b0; branch_in = 1'b0;
        alu_in = 32'd0; rs2_in = 32'd0;
        exe_rs1_addr = 5'd0; exe_rs2_addr = 5'd0;
        exe_uses_rs1 = 1'b0; exe_uses_rs2 = 1'b0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
    endtask

    task automatic set_mem(input logic [2:0] fn3, input logic [4:0] rd,
                           input logic we, input logic [31:0] addr,
                           input logic [31:0] data);
        valid_in = 1'b1; mem_en_in = 1'b1; mem_we_in = we;
        wb_en_in = !we; alu_in = addr; rs2_in = data;
        inst_in = {17'd0, fn3, rd, 7'b0000011};
    endtask

    task automatic test_reset();
        idle_inputs();
        async_rst_n = 1'b0;
        #2;
        checks++;
        if ({bus_req, bus_we, bus_lock} !== 3'b000) begin
            errors++; $display("FAIL reset_bus_ctl: got %b exp 000", {bus_req, bus_we, bus_lock});
        end
        checks++;
        if ({bus_addr, bus_mask, bus_wdata} !== '0) begin
            errors++; $display("FAIL reset_bus_data: got %h/%h/%h exp 0", bus_addr, bus_mask, bus_wdata);
        end
        checks++;
        if ({wb_valid, wb_rd, wb_data, exc_valid, exc_cause} !== '0) begin
            errors++; $display("FAIL reset_wb_exc: got %b %h %h %b %h exp 0", wb_valid, wb_rd, wb_data, exc_valid, exc_cause);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b exp 0", stall);
        end
        repeat (2) tick();
        async_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_branch();
        valid_in = 1'b1; wb_en_in = 1'b1; branch_in = 1'b1;
        inst_in = {20'd0, 5'd3, 7'b0110011};
        alu_in = 32'hCAFE_0001;
        #1;
        checks++;
        if (pc_jmp !== 1'b1 || pc_target !== 30'h32BF_8000) begin
            errors++; $display("FAIL branch: got %b %h exp 1 32bf8000", pc_jmp, pc_target);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL alu_stall: got %b exp 0", stall);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hCAFE_0001) begin
            errors++; $display("FAIL alu_wb: got %b %0d %h exp 1 3 cafe0001", wb_valid, wb_rd, wb_data);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (pc_jmp !== 1'b0) begin
            errors++; $display("FAIL flush_jmp: got %b exp 0", pc_jmp);
        end
        tick();
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL flush_wb: got %b exp 0", wb_valid);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_store_word();
        int stall_cnt = 0;
        set_mem(3'b010, 5'd0, 1'b1, 32'h100, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL sw_entry_stall: got %b exp 1", stall);
        end
        tick();
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 30'h40 || bus_mask !== 4'hF || bus_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL sw_bus: got req=%b we=%b addr=%h mask=%h data=%h exp 1 1 40 f deadbeef", bus_req, bus_we, bus_addr, bus_mask, bus_wdata);
        end
        for (int i = 0; i < 4; i++) begin
            bus_ack = (i == 3);
            #1;
            if (stall === 1'b1) stall_cnt++;
            checks++;
            if (bus_req !== 1'b1 || bus_addr !== 30'h40) begin
                errors++; $display("FAIL sw_hold_%0d: got req=%b addr=%h exp 1 40", i, bus_req, bus_addr);
            end
            tick();
        end
        bus_ack = 1'b0;
        checks++;
        if (stall_cnt !== 4) begin
            errors++; $display("FAIL sw_stall_cycles: got %0d exp 4", stall_cnt);
        end
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL sw_release: got req=%b stall=%b exp 0 0", bus_req, stall);
        end
        tick();
        valid_in = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || exc_valid !== 1'b0) begin
            errors++; $display("FAIL sw_no_wb: got wb=%b exc=%b exp 0 0", wb_valid, exc_valid);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_store_lanes();
        logic [2:0]  fn3 [2]  = '{3'b000, 3'b001};
        logic [31:0] addr [2] = '{32'h102, 32'h106};
        logic [31:0] data [2] = '{32'h1122_33AB, 32'h5566_1234};
        logic [31:0] expd [2] = '{32'hABAB_ABAB, 32'h1234_1234};
        logic [3:0]  expm [2] = '{4'b0100, 4'b1100};
        for (int i = 0; i < 2; i++) begin
            set_mem(fn3[i], 5'd0, 1'b1, addr[i], data[i]);
            tick();
            checks++;
            if (bus_wdata !== expd[i] || bus_mask !== expm[i]) begin
                errors++; $display("FAIL store_lane_%0d: got %h/%b exp %h/%b", i, bus_wdata, bus_mask, expd[i], expm[i]);
            end
            bus_ack = 1'b1;
            tick();
            bus_ack = 1'b0;
            tick();
            idle_inputs();
            tick();
        end
    endtask

    task automatic test_loads();
        logic [2:0]  fn3 [5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] addr [5] = '{32'h203, 32'h201, 32'h202, 32'h202, 32'h200};
        logic [31:0] rdat [5] = '{32'h8000_0000, 32'h0000_F000, 32'h8001_7777, 32'h8001_7777, 32'h1234_5678};
        logic [31:0] expv [5] = '{32'hFFFF_FF80, 32'h0000_00F0, 32'hFFFF_8001, 32'h0000_8001, 32'h1234_5678};
        for (int i = 0; i < 5; i++) begin
            set_mem(fn3[i], 5'd7, 1'b0, addr[i], 32'd0);
            tick();
            checks++;
            if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== addr[i][31:2]) begin
                errors++; $display("FAIL load_req_%0d: got req=%b we=%b addr=%h exp 1 0 %h", i, bus_req, bus_we, bus_addr, addr[i][31:2]);
            end
            bus_rdata = rdat[i];
            bus_ack = 1'b1;
            tick();
            bus_ack = 1'b0;
            checks++;
            if (stall !== 1'b0 || wb_valid !== 1'b0) begin
                errors++; $display("FAIL load_resp_%0d: got stall=%b wb=%b exp 0 0", i, stall, wb_valid);
            end
            tick();
            idle_inputs();
            checks++;
            if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== expv[i]) begin
                errors++; $display("FAIL load_wb_%0d: got %b %0d %h exp 1 7 %h", i, wb_valid, wb_rd, wb_data, expv[i]);
            end
            tick();
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++; $display("FAIL load_wb_pulse_%0d: got %b exp 0", i, wb_valid);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  fn3 [2]  = '{3'b001, 3'b010};
        logic        we [2]   = '{1'b0, 1'b1};
        logic [31:0] addr [2] = '{32'h101, 32'h102};
        logic [1:0]  cause [2] = '{2'd0, 2'd1};
        for (int i = 0; i < 2; i++) begin
            set_mem(fn3[i], 5'd4, we[i], addr[i], 32'h55);
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++; $display("FAIL mis_stall_%0d: got %b exp 0", i, stall);
            end
            tick();
            idle_inputs();
            checks++;
            if (exc_valid !== 1'b1 || exc_cause !== cause[i] || bus_req !== 1'b0 || wb_valid !== 1'b0) begin
                errors++; $display("FAIL mis_exc_%0d: got exc=%b cause=%0d req=%b wb=%b exp 1 %0d 0 0", i, exc_valid, exc_cause, bus_req, wb_valid, cause[i]);
            end
            tick();
            checks++;
            if (exc_valid !== 1'b0 || bus_req !== 1'b0) begin
                errors++; $display("FAIL mis_pulse_%0d: got exc=%b req=%b exp 0 0", i, exc_valid, bus_req);
            end
        end
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        set_mem(3'b010, 5'd8, 1'b0, 32'h300, 32'd0);
        tick();
        for (int i = 0; i < 20 && bus_req === 1'b1; i++) begin
            req_cnt++;
            tick();
        end
        checks++;
        if (req_cnt !== 4) begin
            errors++; $display("FAIL timeout_req_cycles: got %0d exp 4", req_cnt);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL timeout_stall: got %b exp 0", stall);
        end
        tick();
        idle_inputs();
        checks++;
        if (exc_valid !== 1'b1 || exc_cause !== 2'd2 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_exc: got exc=%b cause=%0d wb=%b exp 1 2 0", exc_valid, exc_cause, wb_valid);
        end
        tick();
    endtask

    task automatic test_err_over_ack();
        set_mem(3'b010, 5'd0, 1'b1, 32'h400, 32'h1);
        tick();
        bus_ack = 1'b1;
        bus_err = 1'b1;
        tick();
        bus_ack = 1'b0;
        bus_err = 1'b0;
        tick();
        idle_inputs();
        checks++;
        if (exc_valid !== 1'b1 || exc_cause !== 2'd3) begin
            errors++; $display("FAIL err_ack: got exc=%b cause=%0d exp 1 3", exc_valid, exc_cause);
        end
        tick();
    endtask

    task automatic test_flush_access();
        set_mem(3'b010, 5'd9, 1'b0, 32'h500, 32'd0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (bus_req !== 1'b1) begin
            errors++; $display("FAIL flush_access_req: got %b exp 1", bus_req);
        end
        bus_rdata = 32'h0BAD_F00D;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        tick();
        idle_inputs();
        checks++;
        if (wb_valid !== 1'b0 || exc_valid !== 1'b0) begin
            errors++; $display("FAIL flush_access_drop: got wb=%b exc=%b exp 0 0", wb_valid, exc_valid);
        end
        tick();
    endtask

    task automatic test_load_use();
        clk_en = 1'b0;
        set_mem(3'b010, 5'd5, 1'b0, 32'h600, 32'd0);
        exe_rs2_addr = 5'd5;
        exe_uses_rs2 = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL load_use_hit: got %b exp 1", stall);
        end
        inst_in[11:7] = 5'd0;
        exe_rs2_addr = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL load_use_x0: got %b exp 0", stall);
        end
        inst_in[11:7] = 5'd5;
        exe_rs1_addr = 5'd5;
        exe_rs2_addr = 5'd6;
        exe_uses_rs1 = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL load_use_unused_rs1: got %b exp 0", stall);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_access();
        set_mem(3'b010, 5'd10, 1'b0, 32'h700, 32'd0);
        tick();
        tick();
        checks++;
        if (bus_req !== 1'b1) begin
            errors++; $display("FAIL rst_acc_req: got %b exp 1", bus_req);
        end
        idle_inputs();
        async_rst_n = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rst_acc_drop: got req=%b stall=%b exp 0 0", bus_req, stall);
        end
        tick();
        async_rst_n = 1'b1;
        bus_ack = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        bus_ack = 1'b0;
        tick();
        checks++;
        if (bus_req !== 1'b0 || wb_valid !== 1'b0 || exc_valid !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rst_acc_late_ack: got req=%b wb=%b exc=%b stall=%b exp 0 0 0 0", bus_req, wb_valid, exc_valid, stall);
        end
    endtask

    initial begin
        test_reset();
        test_alu_branch();
        test_store_word();
        test_store_lanes();
        test_loads();
        test_misaligned();
        test_timeout();
        test_err_over_ack();
        test_flush_access();
        test_load_use();
        test_reset_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
